ipml_prefetch_rd_ctrl_v2: RTL and testbench

Parametrised read-side prefetch (first-word-fall-through) controller for the ipml FIFO family.
- Sits between the FIFO pointer controller / SDPRAM read port and the consumer.
- Converts a standard-read FIFO into a valid/ready FWFT interface.
- Supports RAM read latency of 1–3 cycles (unregistered or registered RAM output) and a configurable skid-buffer depth.
- Reports occupancy; sustains one word per cycle.

---
 rtl/ipml_prefetch_pkg.sv | 28 ++
 rtl/ipml_skid_ring_v2.sv | 69 ++++++
 rtl/ipml_prefetch_rd_ctrl_v2.sv | 103 ++++++++++
 tb/tb_ipml_prefetch_rd_ctrl_v2.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipml_prefetch_pkg.sv
// Shared constants, helpers and parameter-legality checks for the ipml
// prefetch read controller family.
package ipml_prefetch_pkg;

  localparam int RAM_LAT_MAX    = 3;
  localparam int SKID_DEPTH_MAX = 16;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

`ifndef IPML_PREFETCH_CHECKS_DEFINED
`define IPML_PREFETCH_CHECKS_DEFINED
// Elaboration-time range check; expands to a labelled generate-if that
// stops elaboration when the parameter value is outside [lo, hi].
`define IPML_PREFETCH_CHECK_RANGE(lbl, val, lo, hi) \
  if (((val) < (lo)) || ((val) > (hi))) begin : lbl \
    $error("ipml_prefetch: parameter value %0d outside legal range [%0d,%0d]", (val), (lo), (hi)); \
  end
`endif

// File: rtl/ipml_skid_ring_v2.sv
// Circular skid buffer: registered storage, write/read pointers that wrap
// at DEPTH-1 (any depth, not only powers of two), and an occupancy count.
// The head entry is presented combinationally from registered storage.
module ipml_skid_ring_v2
  import ipml_prefetch_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head_data,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_full,
  output logic              o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_pop;

  // Next pointer value with explicit wrap so odd depths work.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_empty     = (r_count == '0);
  assign o_full      = (r_count == CNT_DEPTH);
  assign o_count     = r_count;
  assign w_pop       = i_pop & ~o_empty;
  assign o_head_data = r_mem[r_rptr];

  // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= ptr_next(r_wptr);
      if (w_pop)  r_rptr <= ptr_next(r_rptr);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; cleared on reset so the head reads zero out of reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_push) begin
      r_mem[r_wptr] <= i_push_data;
    end
  end

endmodule

// File: rtl/ipml_prefetch_rd_ctrl_v2.sv
// First-word-fall-through read controller for the ipml FIFO family.
// Issues SDPRAM reads ahead of the consumer, tracks reads in flight through
// a RAM_LAT-deep flag pipe and lands returned words in a skid ring.
// Optional macro IPML_PREFETCH_ZERO_OUT_EN: when defined, rd_data is forced
// to zero while rd_vld is low; otherwise rd_data shows the ring head always.
module ipml_prefetch_rd_ctrl_v2
  import ipml_prefetch_pkg::*;
#(
  parameter  int DATA_W     = 32,
  parameter  int RAM_LAT    = 1,
  parameter  int SKID_DEPTH = RAM_LAT + 1,
  localparam int LVL_W      = clog2(SKID_DEPTH + RAM_LAT + 1)
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              ram_empty,
  output logic              ram_rd_en,
  input  logic [DATA_W-1:0] ram_rd_data,
  input  logic              rd_en,
  output logic              rd_vld,
  output logic [DATA_W-1:0] rd_data,
  output logic [LVL_W-1:0]  level
);

  `IPML_PREFETCH_CHECK_RANGE(g_chk_data_w, DATA_W, 1, 1152)
  `IPML_PREFETCH_CHECK_RANGE(g_chk_ram_lat, RAM_LAT, 1, RAM_LAT_MAX)
  `IPML_PREFETCH_CHECK_RANGE(g_chk_skid_depth, SKID_DEPTH, RAM_LAT + 1, SKID_DEPTH_MAX)

  localparam logic [LVL_W:0] SKID_LIMIT = (LVL_W + 1)'(SKID_DEPTH);

  logic [RAM_LAT-1:0] r_pipe;
  logic [LVL_W-1:0]   w_inflight;
  logic [LVL_W-1:0]   w_count;
  logic [LVL_W:0]     w_demand;
  logic [DATA_W-1:0]  w_head;
  logic               w_pop;
  logic               w_push;
  logic               w_full;
  logic               w_empty;
  logic               w_issue;

  // Consumer handshake: rd_vld is high whenever the ring holds a word and
  // rd_data is that word; a word is consumed on a cycle with rd_vld & rd_en.
  // rd_vld never waits on rd_en, and rd_en while rd_vld is low does nothing.
  assign rd_vld = ~w_empty;
  assign w_pop  = rd_vld & rd_en;
  assign w_push = r_pipe[RAM_LAT-1];

  // Count reads in flight: one per set bit in the issue pipe.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RAM_LAT; i++) begin
      w_inflight = w_inflight + LVL_W'(r_pipe[i]);
    end
  end

  // Issue only if every word already committed (stored or in flight), less
  // the one leaving this cycle, plus this new one still fits in the ring.
  assign w_demand  = {1'b0, w_count} + {1'b0, w_inflight} - (LVL_W + 1)'(w_pop);
  assign w_issue   = ~ram_empty & (w_demand < SKID_LIMIT);
  assign ram_rd_en = w_issue;
  assign level     = w_count + w_inflight;

  // Issue-flag pipe aligned with the SDPRAM read latency; its last stage
  // marks the cycle in which ram_rd_data carries the issued word.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= w_issue;
      for (int i = 1; i < RAM_LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  ipml_skid_ring_v2 #(
    .DATA_W (DATA_W),
    .DEPTH  (SKID_DEPTH),
    .CNT_W  (LVL_W)
  ) u_ring (
    .i_clk       (rd_clk),
    .i_rst       (rd_rst),
    .i_push      (w_push),
    .i_push_data (ram_rd_data),
    .i_pop       (w_pop),
    .o_head_data (w_head),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

`ifdef IPML_PREFETCH_ZERO_OUT_EN
  assign rd_data = rd_vld ? w_head : '0;
`else
  assign rd_data = w_head;
`endif

  // The issue accounting must never let a returning word hit a full ring.
  a_no_push_when_full: assert property (@(posedge rd_clk) disable iff (rd_rst)
    !(w_push && w_full));

endmodule

// File: tb/tb_ipml_prefetch_rd_ctrl_v2.sv
// Bench for ipml_prefetch_rd_ctrl_v2: three configurations side by side
// (RAM_LAT/SKID_DEPTH = 1/2, 3/4, 2/3), each fed by a behavioural SDPRAM
// with a source word list and a read-latency pipe.
module tb_ipml_prefetch_rd_ctrl_v2;

  logic clk;
  logic rst;

  logic [2:0]      hold;
  logic [2:0]      rd_en;
  logic [2:0]      ram_empty;
  logic [2:0]      ram_rd_en;
  logic [2:0]      rd_vld;
  logic [2:0][7:0] ram_data;
  logic [2:0][7:0] rd_data;
  logic [2:0][3:0] lvl;

  logic [7:0] src [3][64];
  logic [6:0] src_n [3];

  logic [7:0] exp_q[$];
  int n_cmp;
  int n_err;

  typedef struct {
    logic       rd_en;
    logic       hold;
    logic       exp_en;
    logic       exp_vld;
    logic [7:0] exp_data;
    logic [3:0] exp_lvl;
  } vec_t;

  vec_t v1[6];

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L  = (g == 0) ? 1 : (g == 1) ? 3 : 2;
    localparam int D  = (g == 0) ? 2 : (g == 1) ? 4 : 3;
    localparam int LW = ipml_prefetch_pkg::clog2(D + L + 1);

    logic [LW-1:0] w_lvl;
    logic [7:0]    r_rpipe [L];
    logic [6:0]    r_idx;

    assign ram_empty[g] = hold[g] | (r_idx >= src_n[g]);
    assign ram_data[g]  = r_rpipe[L-1];
    assign lvl[g]       = 4'(w_lvl);

    // Behavioural SDPRAM: read address advances on issue, data emerges L cycles later.
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        r_idx <= 7'd0;
      end else begin
        if (ram_rd_en[g]) r_idx <= r_idx + 7'd1;
        r_rpipe[0] <= src[g][r_idx[5:0]];
        for (int i = 1; i < L; i++) r_rpipe[i] <= r_rpipe[i-1];
      end
    end

    ipml_prefetch_rd_ctrl_v2 #(
      .DATA_W     (8),
      .RAM_LAT    (L),
      .SKID_DEPTH (D)
    ) u_dut (
      .rd_clk      (clk),
      .rd_rst      (rst),
      .ram_empty   (ram_empty[g]),
      .ram_rd_en   (ram_rd_en[g]),
      .ram_rd_data (ram_data[g]),
      .rd_en       (rd_en[g]),
      .rd_vld      (rd_vld[g]),
      .rd_data     (rd_data[g]),
      .level       (w_lvl)
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_check(input string name, input logic [7:0] act);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got %0h expected no further word", name, act);
    end else begin
      e = exp_q.pop_front();
      chk(name, 32'(act), 32'(e));
    end
  endtask

  task automatic drain(input int g, input string name);
    for (int t = 0; t < 60 && exp_q.size() != 0; t++) begin
      @(negedge clk);
      rd_en[g] = 1'b1;
      #1;
      if (rd_vld[g]) pop_check(name, rd_data[g]);
    end
    chk({name, "_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int first;
    int n_iss;
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    hold  = 3'b111;
    rd_en = 3'b000;
    for (int g = 0; g < 3; g++) src_n[g] = 7'd0;

    v1[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0};
    v1[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'd1};
    v1[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 4'd2};
    v1[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 4'd2};
    v1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 4'd1};
    v1[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0};

    // Reset state of all three configurations.
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("rst_ram_rd_en", 32'(ram_rd_en[g]), 32'd0);
      chk("rst_rd_vld", 32'(rd_vld[g]), 32'd0);
      chk("rst_rd_data", 32'(rd_data[g]), 32'd0);
      chk("rst_level", 32'(lvl[g]), 32'd0);
    end
    rst = 1'b0;

    // Test 1: RAM_LAT=1, depth 2, three words, cycle-exact table.
    src[0][0] = 8'h11;
    src[0][1] = 8'h22;
    src[0][2] = 8'h33;
    src_n[0]  = 7'd3;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rd_en[0] = v1[i].rd_en;
      hold[0]  = v1[i].hold;
      #1;
      chk("t1_ram_rd_en", 32'(ram_rd_en[0]), 32'(v1[i].exp_en));
      chk("t1_rd_vld", 32'(rd_vld[0]), 32'(v1[i].exp_vld));
      chk("t1_level", 32'(lvl[0]), 32'(v1[i].exp_lvl));
      if (v1[i].exp_vld) chk("t1_rd_data", 32'(rd_data[0]), 32'(v1[i].exp_data));
    end
    rd_en[0] = 1'b0;

    // Test 2: RAM_LAT=3, depth 4, 8 words streaming at full rate.
    for (int i = 0; i < 8; i++) begin
      src[1][i] = 8'h40 + 8'(i);
      exp_q.push_back(8'h40 + 8'(i));
    end
    src_n[1] = 7'd8;
    first = -1;
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      hold[1]  = 1'b0;
      rd_en[1] = 1'b1;
      #1;
      chk("t2_level_le4", (lvl[1] <= 4'd4) ? 32'd1 : 32'd0, 32'd1);
      chk("t2_rd_vld", 32'(rd_vld[1]), (t >= 4 && t < 12) ? 32'd1 : 32'd0);
      if (rd_vld[1] && first < 0) first = t;
      if (rd_vld[1]) pop_check("t2_data", rd_data[1]);
    end
    chk("t2_first_vld_cycle", 32'(first), 32'd4);
    chk("t2_left", 32'(exp_q.size()), 32'd0);

    // Test 3: consumer stall with 8 words available, then resume.
    @(negedge clk);
    rd_en[1] = 1'b0;
    hold[1]  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      src[1][8+i] = 8'h60 + 8'(i);
      exp_q.push_back(8'h60 + 8'(i));
    end
    src_n[1] = 7'd16;
    n_iss = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      hold[1] = 1'b0;
      #1;
      if (ram_rd_en[1]) n_iss++;
      if (t >= 4) begin
        chk("t3_stall_vld", 32'(rd_vld[1]), 32'd1);
        chk("t3_stall_data", 32'(rd_data[1]), 32'h60);
      end
    end
    chk("t3_issue_count", 32'(n_iss), 32'd4);
    chk("t3_stall_level", 32'(lvl[1]), 32'd4);
    drain(1, "t3_data");
    @(negedge clk);
    rd_en[1] = 1'b0;
    #1;
    chk("t3_after_vld", 32'(rd_vld[1]), 32'd0);
    chk("t3_after_level", 32'(lvl[1]), 32'd0);
`ifdef IPML_PREFETCH_ZERO_OUT_EN
    // Test 6: empty buffer drives zero data.
    chk("t6_zero_out", 32'(rd_data[1]), 32'd0);
`endif

    // Test 4: depth 3 (non-power-of-two), 20 words, random consumer.
    for (int i = 0; i < 20; i++) begin
      src[2][i] = 8'h80 + 8'(i);
      exp_q.push_back(8'h80 + 8'(i));
    end
    src_n[2] = 7'd20;
    for (int t = 0; t < 400 && exp_q.size() != 0; t++) begin
      @(negedge clk);
      hold[2]  = 1'b0;
      rd_en[2] = 1'($urandom_range(0, 1));
      #1;
      chk("t4_level_le3", (lvl[2] <= 4'd3) ? 32'd1 : 32'd0, 32'd1);
      if (rd_vld[2] && rd_en[2]) pop_check("t4_data", rd_data[2]);
    end
    chk("t4_left", 32'(exp_q.size()), 32'd0);

    // Test 5: reset with two reads in flight, then refill.
    @(negedge clk);
    rd_en[2] = 1'b0;
    hold[2]  = 1'b1;
    for (int i = 0; i < 6; i++) src[2][20+i] = 8'hC0 + 8'(i);
    src_n[2] = 7'd26;
    @(negedge clk);
    hold[2] = 1'b0;
    #1;
    chk("t5_issue0", 32'(ram_rd_en[2]), 32'd1);
    @(negedge clk);
    #1;
    @(negedge clk);
    #1;
    chk("t5_pre_level", 32'(lvl[2]), 32'd2);
    chk("t5_pre_vld", 32'(rd_vld[2]), 32'd0);
    rst  = 1'b1;
    hold = 3'b111;
    for (int g = 0; g < 3; g++) src_n[g] = 7'd0;
    @(posedge clk);
    #1;
    chk("t5_rst_vld", 32'(rd_vld[2]), 32'd0);
    chk("t5_rst_level", 32'(lvl[2]), 32'd0);
    chk("t5_rst_ram_rd_en", 32'(ram_rd_en[2]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      src[2][i] = 8'hA0 + 8'(i);
      exp_q.push_back(8'hA0 + 8'(i));
    end
    src_n[2] = 7'd4;
    hold[2]  = 1'b0;
    drain(2, "t5_data");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
